// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller: FSM state codes,
// 2-bit branch-history counter encodings and the instruction size.
package branch_redirect_ctrl_pkg;

  // Controller FSM states, kept as plain constants for legacy tools
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_REDIRECT = 2'd1;
  localparam state_t ST_FLUSH    = 2'd2;

  // 2-bit saturating branch-history counter encodings
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  // Fall-through distance for a not-taken branch
  localparam int unsigned INSN_BYTES = 4;

  // Move a counter one step toward taken/not-taken, pinned at the ends
  function automatic logic [1:0] sat_update(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_bht_2bit.sv
// Branch history table: an array of 2-bit saturating counters with one
// combinational read port for fetch and one update port for resolution.
// A same-index read during an update returns the value before the update.
module bht_2bit
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [1:0] cnt_q [DEPTH];

  assign rd_taken = cnt_q[rd_idx][1];

  // Every entry starts weakly not-taken; resolved branches train one entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= WNT;
      end
    end else if (upd_en) begin
      cnt_q[upd_idx] <= sat_update(cnt_q[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch resolution controller between IF and EX. Detects mispredictions
// from the EX comparator result, requests a redirect from IF, holds flush
// and stall through the handshake and drain, trains the BHT and keeps
// branch / misprediction statistics.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int IDX_W        = 6,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             flush,
  output logic             ex_stall,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  // Drain counter only needs to hold FLUSH_CYCLES-1; keep at least one bit
  localparam int FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int FC_INIT = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;

  state_t          state;
  logic [FC_W-1:0] flush_cnt;
  logic            resolve;
  logic            mispredict;
  logic            unused_if_pc_bits;

  // Only one branch is in flight: resolution is accepted in IDLE only
  assign resolve    = ex_valid & ex_is_branch & (state == ST_IDLE);
  assign mispredict = resolve & (ex_taken != ex_pred_taken);

  // Outputs decode straight from state so reset clears them asynchronously
  assign redirect_valid = (state == ST_REDIRECT);
  assign flush          = (state != ST_IDLE);
  assign ex_stall       = (state != ST_IDLE);

  // Fetch PC bits outside the index field do not affect prediction
  assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  // Redirect/flush sequencing and capture of the corrected fetch address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      flush_cnt   <= '0;
      redirect_pc <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mispredict) begin
            state       <= ST_REDIRECT;
            redirect_pc <= ex_taken ? ex_target : ex_pc + XLEN'(INSN_BYTES);
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            if (FLUSH_CYCLES == 0) begin
              state <= ST_IDLE;
            end else begin
              state     <= ST_FLUSH;
              flush_cnt <= FC_W'(FC_INIT);
            end
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            flush_cnt <= flush_cnt - FC_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Wrapping statistics for resolved branches and mispredictions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve)    branch_cnt  <= branch_cnt + CNT_W'(1);
      if (mispredict) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

  bht_2bit #(
    .IDX_W (IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (if_pc[IDX_W+1:2]),
    .rd_taken  (pred_taken),
    .upd_en    (resolve),
    .upd_idx   (ex_pc[IDX_W+1:2]),
    .upd_taken (ex_taken)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios plus a
// randomized run, all compared against a transaction-level reference model.
module tb_branch_redirect_ctrl;

  localparam int XLEN         = 64;
  localparam int IDX_W        = 6;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 32;

  logic             clk;
  logic             rst_n;
  logic             ex_valid;
  logic             ex_is_branch;
  logic             ex_taken;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_target;
  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             redirect_ready;
  logic             flush;
  logic             ex_stall;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  int checks;
  int failures;

  // Reference model: per-entry counters, statistics, and the outstanding
  // redirect request plus how many drain cycles remain after acceptance
  int               m_bht [2**IDX_W];
  logic [CNT_W-1:0] m_bcnt;
  logic [CNT_W-1:0] m_mcnt;
  bit               m_pending;
  int               m_flush_left;
  logic [XLEN-1:0]  m_rpc;

  branch_redirect_ctrl #(
    .XLEN         (XLEN),
    .IDX_W        (IDX_W),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_taken       (ex_taken),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .flush          (flush),
    .ex_stall       (ex_stall),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  // Free-running clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int bidx(input logic [XLEN-1:0] pc);
    return int'(pc[IDX_W+1:2]);
  endfunction

  function automatic logic m_pred(input logic [XLEN-1:0] pc);
    return (m_bht[bidx(pc)] >= 2) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic m_busy();
    return (m_pending || m_flush_left > 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2**IDX_W; i++) m_bht[i] = 1;
    m_bcnt = '0;
    m_mcnt = '0;
    m_pending = 1'b0;
    m_flush_left = 0;
    m_rpc = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    bit resolve;
    int i;
    if (!rst_n) return;
    resolve = ex_valid && ex_is_branch && !m_busy();
    if (m_pending) begin
      if (redirect_ready) begin
        m_pending = 1'b0;
        m_flush_left = FLUSH_CYCLES;
      end
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end
    if (resolve) begin
      m_bcnt++;
      i = bidx(ex_pc);
      if (ex_taken) m_bht[i] = (m_bht[i] < 3) ? m_bht[i] + 1 : 3;
      else          m_bht[i] = (m_bht[i] > 0) ? m_bht[i] - 1 : 0;
      if (ex_taken != ex_pred_taken) begin
        m_mcnt++;
        m_pending = 1'b1;
        m_rpc = ex_taken ? ex_target : ex_pc + 64'd4;
      end
    end
  endtask

  // One clock: model follows, outputs then settle 2 ns after the edge
  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0;
    ex_is_branch = 1'b0;
    ex_taken = 1'b0;
    ex_pred_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_ex();
    ex_pc = '0;
    ex_target = '0;
    if_pc = 64'h8000_0000;
    redirect_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("[TB] FAIL reset_pred got=%0b exp=0", pred_taken); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rv got=%0b exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 64'h0) begin failures++; $display("[TB] FAIL reset_rpc got=%h exp=0", redirect_pc); end
    checks++; if (flush !== 1'b0 || ex_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_flush_stall got=%0b%0b exp=00", flush, ex_stall); end
    checks++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin failures++; $display("[TB] FAIL reset_cnt got=%0d/%0d exp=0/0", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_mispredict_taken();
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_taken = 1'b1; ex_pred_taken = 1'b0;
    ex_pc = 64'h8000_0010; ex_target = 64'h8000_0100; redirect_ready = 1'b1;
    #1;
    checks++; if (ex_stall !== 1'b0) begin failures++; $display("[TB] FAIL mpt_stall_before got=%0b exp=0", ex_stall); end
    tick();
    clear_ex();
    #1;
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("[TB] FAIL mpt_rv got=%0b exp=1", redirect_valid); end
    checks++; if (redirect_pc !== 64'h8000_0100 || redirect_pc !== m_rpc) begin failures++; $display("[TB] FAIL mpt_rpc got=%h exp=%h", redirect_pc, m_rpc); end
    checks++; if (flush !== 1'b1) begin failures++; $display("[TB] FAIL mpt_flush0 got=%0b exp=1", flush); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (redirect_valid !== 1'b0 || flush !== m_busy() || ex_stall !== m_busy() || flush !== (c <= 2)) begin
        failures++;
        $display("[TB] FAIL mpt_drain%0d got rv=%0b fl=%0b st=%0b exp rv=0 fl=%0b", c, redirect_valid, flush, ex_stall, m_busy());
      end
    end
    checks++; if (branch_cnt !== 32'd1 || mispred_cnt !== 32'd1) begin failures++; $display("[TB] FAIL mpt_cnt got=%0d/%0d exp=1/1", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_backpressure();
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_taken = 1'b0; ex_pred_taken = 1'b1;
    ex_pc = 64'h8000_0020; ex_target = 64'h8000_0200; redirect_ready = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      ex_valid = 1'b1; ex_is_branch = 1'b1; ex_taken = 1'b1; ex_pred_taken = 1'b0;
      ex_pc = 64'h8000_0030; ex_target = 64'h8000_0300;
      #1;
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0024 || ex_stall !== 1'b1) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d got rv=%0b rpc=%h st=%0b exp rv=1 rpc=80000024 st=1", c, redirect_valid, redirect_pc, ex_stall);
      end
      checks++; if (branch_cnt !== m_bcnt || branch_cnt !== 32'd2) begin failures++; $display("[TB] FAIL bp_bcnt%0d got=%0d exp=2", c, branch_cnt); end
      tick();
    end
    clear_ex();
    redirect_ready = 1'b1;
    #1;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== m_rpc) begin failures++; $display("[TB] FAIL bp_accept got rv=%0b rpc=%h exp rv=1 rpc=%h", redirect_valid, redirect_pc, m_rpc); end
    repeat (3) tick();
    checks++; if (ex_stall !== 1'b0 || branch_cnt !== 32'd2 || mispred_cnt !== 32'd2) begin failures++; $display("[TB] FAIL bp_done got st=%0b cnt=%0d/%0d exp st=0 cnt=2/2", ex_stall, branch_cnt, mispred_cnt); end
  endtask

  task automatic test_bht_training();
    logic exp_seq [5];
    exp_seq[0] = 1'b1; exp_seq[1] = 1'b1; exp_seq[2] = 1'b1; exp_seq[3] = 1'b1; exp_seq[4] = 1'b0;
    if_pc = 64'h8000_0040;
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("[TB] FAIL bht_init got=%0b exp=0", pred_taken); end
    for (int s = 0; s < 5; s++) begin
      ex_valid = 1'b1; ex_is_branch = 1'b1;
      ex_taken = (s < 3); ex_pred_taken = (s < 3);
      ex_pc = 64'h8000_0040; ex_target = 64'h8000_0400;
      tick();
      clear_ex();
      #1;
      checks++;
      if (pred_taken !== exp_seq[s] || pred_taken !== m_pred(if_pc)) begin
        failures++;
        $display("[TB] FAIL bht_train%0d got=%0b exp=%0b", s, pred_taken, exp_seq[s]);
      end
      checks++; if (redirect_valid !== 1'b0 || ex_stall !== 1'b0) begin failures++; $display("[TB] FAIL bht_noredir%0d got rv=%0b st=%0b exp=0", s, redirect_valid, ex_stall); end
    end
  endtask

  task automatic test_same_index();
    if_pc = 64'h8000_0040;
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_taken = 1'b1; ex_pred_taken = 1'b1;
    ex_pc = 64'h8000_0040; ex_target = 64'h8000_0400;
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("[TB] FAIL same_idx_old got=%0b exp=0", pred_taken); end
    tick();
    clear_ex();
    #1;
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("[TB] FAIL same_idx_new got=%0b exp=1", pred_taken); end
  endtask

  task automatic test_reset_mid();
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_taken = 1'b0; ex_pred_taken = 1'b1;
    ex_pc = 64'h8000_0050; ex_target = 64'h8000_0500; redirect_ready = 1'b0;
    tick();
    clear_ex();
    #1;
    checks++; if (redirect_valid !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_pre got=%0b exp=1", redirect_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0 || ex_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_async got rv=%0b fl=%0b st=%0b exp=000", redirect_valid, flush, ex_stall);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    redirect_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (redirect_valid !== 1'b0 || flush !== 1'b0 || ex_stall !== 1'b0 || branch_cnt !== 32'd0) begin
        failures++;
        $display("[TB] FAIL rstmid_after%0d got rv=%0b fl=%0b st=%0b bc=%0d exp=0", c, redirect_valid, flush, ex_stall, branch_cnt);
      end
    end
    if_pc = 64'h8000_0040;
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_bht got=%0b exp=0", pred_taken); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      ex_valid       = ($urandom_range(0, 9) < 7);
      ex_is_branch   = ($urandom_range(0, 9) < 7);
      ex_taken       = $urandom_range(0, 1) == 1;
      ex_pred_taken  = $urandom_range(0, 1) == 1;
      redirect_ready = $urandom_range(0, 1) == 1;
      ex_pc          = {32'h8000_0000, 24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 7) == 0) ex_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      ex_target      = {$urandom(), $urandom()};
      if_pc          = {32'h8000_0000, 24'h0, 6'($urandom_range(0, 63)), 2'b00};
      #1;
      checks++;
      if (pred_taken !== m_pred(if_pc) || redirect_valid !== m_pending || flush !== m_busy() || ex_stall !== m_busy()) begin
        failures++;
        $display("[TB] FAIL rnd_ctl%0d got pt=%0b rv=%0b fl=%0b st=%0b exp pt=%0b rv=%0b fl=%0b", n, pred_taken, redirect_valid, flush, ex_stall, m_pred(if_pc), m_pending, m_busy());
      end
      checks++;
      if (redirect_pc !== m_rpc || branch_cnt !== m_bcnt || mispred_cnt !== m_mcnt) begin
        failures++;
        $display("[TB] FAIL rnd_data%0d got rpc=%h bc=%0d mc=%0d exp rpc=%h bc=%0d mc=%0d", n, redirect_pc, branch_cnt, mispred_cnt, m_rpc, m_bcnt, m_mcnt);
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_mispredict_taken();
    test_backpressure();
    test_bht_training();
    test_same_index();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
